uart_frame_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 18 +
 rtl/frame_buf.sv | 27 ++
 rtl/uart_frame_rx.sv | 139 +++++++++++++
 tb/tb_uart_frame_rx.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: framing FSM encodings, default sync byte and the
// baud constants used by the byte receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    HUNT    = 3'd0,
    GETLEN  = 3'd1,
    PAYLOAD = 3'd2,
    GETCHK  = 3'd3,
    HOLD    = 3'd4
  } frame_state_e;

  localparam logic [7:0] SYNC_BYTE    = 8'hAA;
  localparam int         CLK_HZ       = 50_000_000;
  localparam int         BAUD         = 115_200;
  localparam int         CLKS_PER_BIT = CLK_HZ / BAUD;

endpackage

// File: rtl/frame_buf.sv
// Payload register file: one write port, one registered read port.
module frame_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  // Rounded up to a power of two so every raddr has a slot; unused slots are never written.
  logic [7:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rstn) rdata <= '0;
    else       rdata <= mem[raddr];
  end

endmodule

// File: rtl/uart_frame_rx.sv
// Sync-hunting, length-prefixed frame collector with XOR checksum and a
// valid/ack hold stage feeding a random-access payload read port.
module uart_frame_rx
  import uart_pkg::*;
#(
  parameter int         MAX_LEN = 16,
  parameter logic [7:0] SYNC    = SYNC_BYTE,
  parameter int         TIMEOUT = 50000,
  localparam int        AW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          rcv,
  input  logic [7:0]    data,
  output logic          frame_valid,
  output logic [7:0]    frame_len,
  input  logic          frame_ack,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic          busy,
  output logic          err_chk,
  output logic          err_len,
  output logic          err_tmo,
  output logic          overrun
);

  localparam int         TW       = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [7:0] LEN_MAX  = 8'(MAX_LEN);

  frame_state_e  state;
  logic [7:0]    len_r, chk_r;
  logic [AW-1:0] idx;
  logic [TW-1:0] tmo;
  logic          we, tmo_hit;

  assign we      = (state == PAYLOAD) && rcv;
  assign tmo_hit = !rcv && (tmo == TMO_LAST);

  frame_buf #(.DEPTH(MAX_LEN), .AW(AW)) u_buf (
    .clk   (clk),
    .rstn  (rstn),
    .we    (we),
    .waddr (idx),
    .wdata (data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= HUNT;
      len_r       <= '0;
      chk_r       <= '0;
      idx         <= '0;
      tmo         <= '0;
      frame_valid <= 1'b0;
      frame_len   <= '0;
      busy        <= 1'b0;
      err_chk     <= 1'b0;
      err_len     <= 1'b0;
      err_tmo     <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      err_chk <= 1'b0;
      err_len <= 1'b0;
      err_tmo <= 1'b0;
      overrun <= 1'b0;
      // busy mirrors the receiving states, so it doubles as the counter enable
      tmo <= (busy && !rcv) ? tmo + 1'b1 : '0;
      unique case (state)
        HUNT: begin
          if (rcv && data == SYNC) begin
            state <= GETLEN;
            busy  <= 1'b1;
          end
        end
        GETLEN: begin
          if (rcv) begin
            if (data == 8'd0 || data > LEN_MAX) begin
              err_len <= 1'b1;
              state   <= HUNT;
              busy    <= 1'b0;
            end else begin
              len_r <= data;
              chk_r <= data;
              idx   <= '0;
              state <= PAYLOAD;
            end
          end else if (tmo_hit) begin
            err_tmo <= 1'b1;
            state   <= HUNT;
            busy    <= 1'b0;
          end
        end
        PAYLOAD: begin
          if (rcv) begin
            chk_r <= chk_r ^ data;
            idx   <= idx + 1'b1;
            if (idx == AW'(len_r - 8'd1)) state <= GETCHK;
          end else if (tmo_hit) begin
            err_tmo <= 1'b1;
            state   <= HUNT;
            busy    <= 1'b0;
          end
        end
        GETCHK: begin
          if (rcv) begin
            busy <= 1'b0;
            if (data == chk_r) begin
              state       <= HOLD;
              frame_valid <= 1'b1;
              frame_len   <= len_r;
            end else begin
              err_chk <= 1'b1;
              state   <= HUNT;
            end
          end else if (tmo_hit) begin
            err_tmo <= 1'b1;
            state   <= HUNT;
            busy    <= 1'b0;
          end
        end
        HOLD: begin
          overrun <= rcv;
          if (frame_ack) begin
            state       <= HUNT;
            frame_valid <= 1'b0;
          end
        end
        default: begin
          state <= HUNT;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Randomized frame stream checked cycle-by-cycle against a queue-based
// frame model, plus directed frames with fixed expected values.
module tb_uart_frame_rx;

  localparam int         MAX_LEN = 16;
  localparam int         TIMEOUT = 20;
  localparam logic [7:0] SYNC    = 8'hAA;
  localparam int         AW      = 4;

  logic          clk = 1'b0, rstn = 1'b0, rcv = 1'b0, frame_ack = 1'b0;
  logic [7:0]    data = '0;
  logic [AW-1:0] rd_addr = '0;
  logic          frame_valid, busy, err_chk, err_len, err_tmo, overrun;
  logic [7:0]    frame_len, rd_data;

  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  uart_frame_rx #(.MAX_LEN(MAX_LEN), .SYNC(SYNC), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rstn(rstn), .rcv(rcv), .data(data),
    .frame_valid(frame_valid), .frame_len(frame_len), .frame_ack(frame_ack),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy),
    .err_chk(err_chk), .err_len(err_len), .err_tmo(err_tmo), .overrun(overrun)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---- reference model: phase + payload queue, checksum folded at the end ----
  logic          s_ok = 1'b0, s_rstn, s_rcv, s_ack;
  logic [7:0]    s_data;
  logic [AW-1:0] s_addr;
  int            m_ph = 0, m_want = 0, m_idle = 0;
  logic [7:0]    m_pl[$], m_frame[$];
  logic          m_fv = 1'b0, m_busy = 1'b0, m_rd_chk = 1'b0;
  logic [7:0]    m_flen = '0, m_rd = '0;
  logic [3:0]    m_pulse = '0;  // {err_chk, err_len, err_tmo, overrun}

  always @(posedge clk) begin
    s_rstn <= rstn; s_rcv <= rcv; s_ack <= frame_ack; s_data <= data; s_addr <= rd_addr;
    s_ok   <= 1'b1;
  end

  task automatic model_step();
    logic [7:0] x;
    if (!s_rstn) begin
      m_ph = 0; m_fv = 0; m_flen = 0; m_busy = 0; m_pulse = 0; m_idle = 0;
      m_rd_chk = 1; m_rd = 0;
      return;
    end
    m_rd_chk = (m_ph == 4) && (s_addr < m_flen);
    if (m_rd_chk) m_rd = m_frame[s_addr];
    m_pulse = 0;
    case (m_ph)
      0: if (s_rcv && s_data == SYNC) begin m_ph = 1; m_idle = 0; end
      4: begin
        if (s_rcv) m_pulse[0] = 1;
        if (s_ack) begin m_ph = 0; m_fv = 0; end
      end
      default: begin
        if (s_rcv) begin
          m_idle = 0;
          if (m_ph == 1) begin
            if (s_data == 0 || s_data > MAX_LEN) begin m_pulse[2] = 1; m_ph = 0; end
            else begin m_want = s_data; m_pl.delete(); m_ph = 2; end
          end else if (m_ph == 2) begin
            m_pl.push_back(s_data);
            if (m_pl.size() == m_want) m_ph = 3;
          end else begin
            x = 8'(m_want);
            foreach (m_pl[i]) x ^= m_pl[i];
            if (s_data == x) begin m_ph = 4; m_fv = 1; m_flen = 8'(m_want); m_frame = m_pl; end
            else begin m_pulse[3] = 1; m_ph = 0; end
          end
        end else begin
          m_idle++;
          if (m_idle == TIMEOUT) begin m_pulse[1] = 1; m_ph = 0; end
        end
      end
    endcase
    m_busy = (m_ph >= 1 && m_ph <= 3);
  endtask

  always @(negedge clk) begin
    if (s_ok) begin
      model_step();
      chk("flags", 32'({frame_valid, busy, err_chk, err_len, err_tmo, overrun}),
          32'({m_fv, m_busy, m_pulse}));
      chk("frame_len", 32'(frame_len), 32'(m_flen));
      if (m_rd_chk) chk("rd_data", 32'(rd_data), 32'(m_rd));
    end
  end

  // ---- stimulus ----
  task automatic put(input logic [7:0] b);
    @(negedge clk); rcv = 1'b1; data = b; frame_ack = 1'b0; rd_addr = AW'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk); rcv = 1'b0; frame_ack = 1'b0; data = 8'($urandom); rd_addr = AW'($urandom);
    end
  endtask

  task automatic rd_at(input logic [AW-1:0] a, input logic [7:0] exp, input string tag);
    @(negedge clk); rcv = 1'b0; frame_ack = 1'b0; rd_addr = a;
    @(negedge clk); chk(tag, 32'(rd_data), 32'(exp));
  endtask

  task automatic ack(input logic with_rcv);
    @(negedge clk); frame_ack = 1'b1; rcv = with_rcv; data = 8'($urandom);
  endtask

  task automatic rand_frame();
    int kind, ng, len, lg, rst_at;
    logic [7:0] b[$];
    logic [7:0] x, p;
    kind = $urandom_range(0, 9);
    ng   = $urandom_range(0, 2);
    repeat (ng) begin
      x = 8'($urandom);
      if (x == SYNC) x = 8'h55;
      b.push_back(x);
    end
    b.push_back(SYNC);
    if (kind == 0) begin
      len = ($urandom_range(0, 1) != 0) ? 0 : $urandom_range(MAX_LEN + 1, 255);
      b.push_back(8'(len));
    end else begin
      len = $urandom_range(1, MAX_LEN);
      b.push_back(8'(len));
      x = 8'(len);
      repeat (len) begin p = 8'($urandom); x ^= p; b.push_back(p); end
      if (kind == 1) x ^= 8'(1 << $urandom_range(0, 7));
      b.push_back(x);
    end
    lg     = (kind == 2) ? $urandom_range(ng, b.size() - 2) : -1;
    rst_at = (kind == 3) ? $urandom_range(ng + 1, b.size() - 1) : -1;
    foreach (b[i]) begin
      if (i == rst_at) begin
        @(negedge clk); rstn = 1'b0; rcv = 1'b0;
        @(negedge clk); rstn = 1'b1;
      end
      put(b[i]);
      idle((i == lg) ? $urandom_range(TIMEOUT - 2, TIMEOUT + 1) : $urandom_range(0, 2));
    end
    idle($urandom_range(1, 3));
    repeat ($urandom_range(0, 3)) begin put(8'($urandom)); idle($urandom_range(0, 1)); end
    ack($urandom_range(0, 1) != 0);
    idle(1);
  endtask

  initial begin
    idle(3);
    chk("reset_valid", 32'(frame_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    @(negedge clk); rstn = 1'b1;
    idle(2);

    // good frame AA 03 11 22 33 03
    put(SYNC); put(8'h03); put(8'h11); put(8'h22); put(8'h33); put(8'h03); idle(1);
    chk("good_valid", 32'(frame_valid), 32'd1);
    chk("good_len", 32'(frame_len), 32'd3);
    rd_at(0, 8'h11, "good_rd0"); rd_at(1, 8'h22, "good_rd1"); rd_at(2, 8'h33, "good_rd2");
    // overrun in HOLD leaves the frame intact
    put(8'h99); idle(1);
    chk("ovr_pulse", 32'(overrun), 32'd1);
    chk("ovr_held", 32'(frame_valid), 32'd1);
    rd_at(1, 8'h22, "ovr_rd1");
    // ack together with rcv: release and overrun both happen
    ack(1'b1); idle(1);
    chk("ack_ovr", 32'(overrun), 32'd1);
    chk("ack_release", 32'(frame_valid), 32'd0);
    idle(2);

    // garbage then frame
    put(8'h55); put(8'h00); put(SYNC); put(8'h01); put(8'h7E); put(8'h7F); idle(1);
    chk("garb_len", 32'(frame_len), 32'd1);
    rd_at(0, 8'h7E, "garb_rd0");
    ack(1'b0); idle(2);

    // illegal lengths, then a legal frame
    put(SYNC); put(8'h00); idle(1);
    chk("len0_err", 32'(err_len), 32'd1);
    put(SYNC); put(8'h11); idle(1);
    chk("len17_err", 32'(err_len), 32'd1);
    put(SYNC); put(8'h01); put(8'h05); put(8'h04); idle(1);
    chk("after_len_valid", 32'(frame_valid), 32'd1);
    ack(1'b0); idle(2);

    // bad checksum
    put(SYNC); put(8'h02); put(8'h10); put(8'h20); put(8'h31); idle(1);
    chk("badchk_err", 32'(err_chk), 32'd1);
    chk("badchk_busy", 32'(busy), 32'd0);
    idle(2);

    // timeout fires after TIMEOUT idle cycles
    put(SYNC); put(8'h02); put(8'h10); idle(TIMEOUT);
    chk("tmo_early", 32'(err_tmo), 32'd0);
    idle(1);
    chk("tmo_fire", 32'(err_tmo), 32'd1);
    chk("tmo_busy", 32'(busy), 32'd0);
    idle(2);
    // a byte on the last idle cycle before expiry keeps the frame alive
    put(SYNC); put(8'h02); put(8'h10); idle(TIMEOUT - 1); put(8'h20); put(8'h32); idle(1);
    chk("tmo_saved", 32'(frame_valid), 32'd1);
    ack(1'b0); idle(2);

    // reset mid-payload
    put(SYNC); put(8'h03); put(8'h11);
    @(negedge clk); rcv = 1'b0; rstn = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_errs", 32'({err_chk, err_len, err_tmo, overrun}), 32'd0);
    rstn = 1'b1;
    idle(2);

    repeat (80) rand_frame();

    // unstructured noise with sync/small-length bias
    repeat (400) begin
      @(negedge clk);
      rcv       = ($urandom_range(0, 1) != 0);
      frame_ack = ($urandom_range(0, 9) == 0);
      rd_addr   = AW'($urandom);
      case ($urandom_range(0, 3))
        0:       data = SYNC;
        1:       data = 8'($urandom_range(0, 3));
        default: data = 8'($urandom);
      endcase
    end
    idle(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
